// File: rtl/lsu_pkg.sv
// Shared encodings for the multi-lane load/store unit: FSM state codes,
// default compute-unit phase values and the lane-pointer width helper.
package lsu_pkg;

  localparam logic [1:0] LSU_IDLE       = 2'd0;
  localparam logic [1:0] LSU_REQUESTING = 2'd1;
  localparam logic [1:0] LSU_WAITING    = 2'd2;
  localparam logic [1:0] LSU_DONE       = 2'd3;

  localparam logic [3:0] CU_REQUEST_DEFAULT = 4'b0011;
  localparam logic [3:0] CU_UPDATE_DEFAULT  = 4'b0110;

  // A single-lane build still needs a one-bit pointer.
  function automatic int lane_ptr_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lsu_next_lane.sv
// Lane scanner: lowest set mask bit strictly above ptr, or the lowest set
// bit overall when first is high.
module lsu_next_lane
  import lsu_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int PTR_W     = lane_ptr_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 first,
  output logic [PTR_W-1:0]     next,
  output logic                 found
);

  // Scanning downward lets the lowest qualifying lane win.
  always_comb begin
    next  = '0;
    found = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(ptr)))) begin
        next  = PTR_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_multilane.sv
// Multi-lane load/store unit: captures per-lane operands under a lane mask and
// serialises one memory transaction per active lane over shared ports.
module lsu_multilane
  import lsu_pkg::*;
#(
  parameter int         DATA_ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH      = 16,
  parameter int         NUM_LANES       = 4,
  parameter logic [3:0] CU_REQUEST      = CU_REQUEST_DEFAULT,
  parameter logic [3:0] CU_UPDATE       = CU_UPDATE_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [3:0]                      cu_state,
  input  logic                            lsu_en,
  input  logic [NUM_LANES-1:0]            lane_mask,
  input  logic                            mem_ren,
  input  logic                            mem_wen,
  input  logic [NUM_LANES*16-1:0]         rs1,
  input  logic [NUM_LANES*16-1:0]         rs2,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lsu_data_out,
  output logic [1:0]                      lsu_state,
  output logic                            lsu_err,
  input  logic                            read_req_rdy,
  output logic [DATA_ADDR_WIDTH-1:0]      read_req_addr,
  output logic                            read_req_addr_val,
  output logic                            read_resp_rdy,
  input  logic [DATA_WIDTH-1:0]           read_resp_data,
  input  logic                            read_resp_data_val,
  input  logic                            write_req_rdy,
  output logic [DATA_ADDR_WIDTH-1:0]      write_req_addr,
  output logic [DATA_WIDTH-1:0]           write_req_data,
  output logic                            write_req_val,
  input  logic                            write_resp_val
);

  localparam int PTR_W = lane_ptr_w(NUM_LANES);

  logic [1:0]                 state, state_nxt;
  logic [PTR_W-1:0]           ptr, lane_nxt;
  logic                       lane_found, op_load, err;
  logic [NUM_LANES-1:0]       mask_q, scan_mask;
  logic [DATA_ADDR_WIDTH-1:0] addr_q   [NUM_LANES];
  logic [15:0]                store_q  [NUM_LANES];
  logic [DATA_WIDTH-1:0]      result_q [NUM_LANES];
  logic                       in_idle, capture_req, op_legal, req_accept, resp_done;
  logic                       unused_rs1;

  // Only the low DATA_ADDR_WIDTH bits of each rs1 lane form the address.
  assign unused_rs1 = ^rs1;

  assign in_idle     = (state == LSU_IDLE);
  assign capture_req = in_idle && lsu_en && (cu_state == CU_REQUEST);
  assign op_legal    = mem_ren ^ mem_wen;
  assign scan_mask   = in_idle ? lane_mask : mask_q;
  assign req_accept  = (state == LSU_REQUESTING) && (op_load ? read_req_rdy : write_req_rdy);
  assign resp_done   = (state == LSU_WAITING) && (op_load ? read_resp_data_val : write_resp_val);

  lsu_next_lane #(.NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_next_lane (
    .mask  (scan_mask),
    .ptr   (ptr),
    .first (in_idle),
    .next  (lane_nxt),
    .found (lane_found)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LSU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE:       if (capture_req && op_legal) state_nxt = lane_found ? LSU_REQUESTING : LSU_DONE;
      LSU_REQUESTING: if (req_accept) state_nxt = LSU_WAITING;
      LSU_WAITING:    if (resp_done) state_nxt = lane_found ? LSU_REQUESTING : LSU_DONE;
      LSU_DONE:       if (cu_state == CU_UPDATE) state_nxt = LSU_IDLE;
      default:        state_nxt = LSU_IDLE;
    endcase
  end

  // Capture, lane pointer and per-lane result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      op_load <= 1'b0;
      mask_q  <= '0;
      err     <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        addr_q[i]   <= '0;
        store_q[i]  <= '0;
        result_q[i] <= '0;
      end
    end else begin
      err <= capture_req && mem_ren && mem_wen;
      if (capture_req && op_legal) begin
        op_load <= mem_ren;
        mask_q  <= lane_mask;
        ptr     <= lane_nxt;
        for (int i = 0; i < NUM_LANES; i++) begin
          addr_q[i]  <= rs1[16*i +: DATA_ADDR_WIDTH];
          store_q[i] <= rs2[16*i +: 16];
        end
      end
      if (resp_done) begin
        if (op_load) result_q[ptr] <= read_resp_data;
        if (lane_found) ptr <= lane_nxt;
      end
    end
  end

  always_comb begin
    read_req_addr_val = 1'b0;
    write_req_val     = 1'b0;
    read_resp_rdy     = 1'b0;
    case (state)
      LSU_REQUESTING: begin
        read_req_addr_val = op_load;
        write_req_val     = !op_load;
      end
      LSU_WAITING: read_resp_rdy = op_load;
      default: ;
    endcase
  end

  assign lsu_state      = state;
  assign lsu_err        = err;
  assign read_req_addr  = addr_q[ptr];
  assign write_req_addr = addr_q[ptr];
  assign write_req_data = DATA_WIDTH'(store_q[ptr]);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
    assign lsu_data_out[g*DATA_WIDTH +: DATA_WIDTH] = result_q[g];
  end

endmodule

// File: tb/tb_lsu_multilane.sv
// Scoreboarded bench for lsu_multilane: a lane-level reference model predicts
// memory transactions and final results; a monitor checks them as they appear.
module tb_lsu_multilane;

  localparam int         NL     = 4;
  localparam int         AW     = 8;
  localparam int         DW     = 16;
  localparam logic [3:0] CU_REQ = 4'b0011;
  localparam logic [3:0] CU_UPD = 4'b0110;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     cu_state;
  logic           lsu_en;
  logic [NL-1:0]  lane_mask;
  logic           mem_ren, mem_wen;
  logic [NL*16-1:0] rs1, rs2;
  logic [NL*DW-1:0] lsu_data_out;
  logic [1:0]     lsu_state;
  logic           lsu_err;
  logic           read_req_rdy, read_req_addr_val, read_resp_rdy, read_resp_data_val;
  logic [AW-1:0]  read_req_addr, write_req_addr;
  logic [DW-1:0]  read_resp_data, write_req_data;
  logic           write_req_rdy, write_req_val, write_resp_val;

  always #5 clk = ~clk;

  lsu_multilane #(
    .DATA_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL),
    .CU_REQUEST(CU_REQ), .CU_UPDATE(CU_UPD)
  ) dut (
    .clk(clk), .reset(reset), .cu_state(cu_state), .lsu_en(lsu_en),
    .lane_mask(lane_mask), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .rs1(rs1), .rs2(rs2), .lsu_data_out(lsu_data_out), .lsu_state(lsu_state),
    .lsu_err(lsu_err), .read_req_rdy(read_req_rdy), .read_req_addr(read_req_addr),
    .read_req_addr_val(read_req_addr_val), .read_resp_rdy(read_resp_rdy),
    .read_resp_data(read_resp_data), .read_resp_data_val(read_resp_data_val),
    .write_req_rdy(write_req_rdy), .write_req_addr(write_req_addr),
    .write_req_data(write_req_data), .write_req_val(write_req_val),
    .write_resp_val(write_resp_val)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [NL*DW-1:0] exp_done[$];
  logic [DW-1:0]    model_out [NL];

  int req_wait    = 0;
  int resp_delay  = 0;
  bit spurious    = 1'b0;
  bit inject_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [NL*DW-1:0] model_vec();
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = model_out[i];
    return v;
  endfunction

  // Memory model: programmable ready stall and response delay, data = 0xA000 + addr.
  initial begin
    int rd_wcnt, wr_wcnt, rd_cnt, wr_cnt;
    bit rd_acc, wr_acc, rd_out, wr_out;
    logic [AW-1:0] rd_addr;
    read_req_rdy = 1'b0; write_req_rdy = 1'b0;
    read_resp_data_val = 1'b0; read_resp_data = '0; write_resp_val = 1'b0;
    rd_wcnt = 0; wr_wcnt = 0; rd_cnt = 0; wr_cnt = 0;
    rd_acc = 0; wr_acc = 0; rd_out = 0; wr_out = 0; rd_addr = '0;
    forever begin
      @(negedge clk); #1;
      read_resp_data_val = 1'b0;
      write_resp_val     = 1'b0;
      if (reset) begin
        rd_acc = 0; wr_acc = 0; rd_out = 0; wr_out = 0;
        read_req_rdy = 1'b0; write_req_rdy = 1'b0;
        rd_wcnt = req_wait; wr_wcnt = req_wait;
        if (inject_resp) begin
          read_resp_data_val = 1'b1;
          read_resp_data     = 16'hBEEF;
        end
      end else begin
        if (rd_acc) begin rd_acc = 0; rd_out = 1; rd_cnt = resp_delay; end
        if (rd_out) begin
          if (rd_cnt == 0) begin
            read_resp_data_val = 1'b1;
            read_resp_data     = 16'hA000 + {8'h00, rd_addr};
            rd_out = 0;
          end else begin
            rd_cnt--;
            if (spurious) write_resp_val = 1'b1;
          end
        end
        if (wr_acc) begin wr_acc = 0; wr_out = 1; wr_cnt = resp_delay; end
        if (wr_out) begin
          if (wr_cnt == 0) begin write_resp_val = 1'b1; wr_out = 0; end
          else wr_cnt--;
        end
        if (read_req_addr_val) begin
          if (rd_wcnt > 0) begin read_req_rdy = 1'b0; rd_wcnt--; end
          else begin read_req_rdy = 1'b1; rd_acc = 1; rd_addr = read_req_addr; end
        end else begin
          read_req_rdy = 1'b0; rd_wcnt = req_wait;
        end
        if (write_req_val) begin
          if (wr_wcnt > 0) begin write_req_rdy = 1'b0; wr_wcnt--; end
          else begin write_req_rdy = 1'b1; wr_acc = 1; end
        end else begin
          write_req_rdy = 1'b0; wr_wcnt = req_wait;
        end
      end
    end
  end

  // Monitor: checks accepted requests, held-request stability and results at DONE entry.
  initial begin
    logic [1:0]       prev_state;
    bit               rd_hold, wr_hold;
    logic [AW-1:0]    hold_rd;
    logic [AW+DW-1:0] hold_wr;
    prev_state = 2'd0; rd_hold = 0; wr_hold = 0; hold_rd = '0; hold_wr = '0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        prev_state = 2'd0; rd_hold = 0; wr_hold = 0;
        continue;
      end
      if (read_req_addr_val) begin
        if (rd_hold) chk("rd_addr_stable", 64'(read_req_addr), 64'(hold_rd));
        if (read_req_rdy) begin
          if (exp_rd.size() == 0) fail("unexpected_read", $sformatf("addr %h", read_req_addr));
          else chk("rd_addr", 64'(read_req_addr), 64'(exp_rd.pop_front()));
          rd_hold = 0;
        end else begin
          rd_hold = 1; hold_rd = read_req_addr;
        end
      end else rd_hold = 0;
      if (write_req_val) begin
        if (wr_hold) chk("wr_req_stable", 64'({write_req_addr, write_req_data}), 64'(hold_wr));
        if (write_req_rdy) begin
          if (exp_wr.size() == 0) fail("unexpected_write", $sformatf("addr %h data %h", write_req_addr, write_req_data));
          else chk("wr_addr_data", 64'({write_req_addr, write_req_data}), 64'(exp_wr.pop_front()));
          wr_hold = 0;
        end else begin
          wr_hold = 1; hold_wr = {write_req_addr, write_req_data};
        end
      end else wr_hold = 0;
      if (lsu_state == 2'd3 && prev_state != 2'd3) begin
        if (exp_done.size() == 0) fail("unexpected_done", "no operation outstanding");
        else chk("done_data", lsu_data_out, exp_done.pop_front());
      end
      prev_state = lsu_state;
    end
  end

  task automatic idle_inputs();
    lsu_en = 1'b0; cu_state = 4'h0; mem_ren = 1'b0; mem_wen = 1'b0;
    lane_mask = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    for (int i = 0; i < NL; i++) model_out[i] = '0;
  endtask

  // Predict the transaction list and final results, then present one request phase.
  task automatic start_op(input bit ld, input logic [NL-1:0] m,
                          input logic [NL*16-1:0] a, input logic [NL*16-1:0] d);
    logic [15:0] al, dl;
    for (int i = 0; i < NL; i++) begin
      if (m[i]) begin
        al = a[i*16 +: 16];
        dl = d[i*16 +: 16];
        if (ld) begin
          exp_rd.push_back(al[AW-1:0]);
          model_out[i] = 16'hA000 + {8'h00, al[AW-1:0]};
        end else begin
          exp_wr.push_back({al[AW-1:0], dl});
        end
      end
    end
    exp_done.push_back(model_vec());
    @(negedge clk);
    lsu_en = 1'b1; cu_state = CU_REQ; mem_ren = ld; mem_wen = !ld;
    lane_mask = m; rs1 = a; rs2 = d;
    @(negedge clk);
    lsu_en = 1'b0; cu_state = 4'h0;
    mem_ren = 1'($urandom); mem_wen = 1'($urandom); lane_mask = NL'($urandom);
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
  endtask

  task automatic finish_op(input int exp_lat);
    int c;
    c = 1;
    while (lsu_state != 2'd3 && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (lsu_state != 2'd3) begin
      fail("done_timeout", $sformatf("state %0d after %0d cycles", lsu_state, c));
      do_reset();
      return;
    end
    if (exp_lat >= 0) chk("done_latency", 64'(c), 64'(exp_lat));
    lsu_en = 1'b1; cu_state = CU_REQ; mem_ren = 1'b1; mem_wen = 1'b0; lane_mask = 4'hF;
    @(negedge clk);
    lsu_en = 1'b0; cu_state = CU_UPD; mem_ren = 1'b0;
    chk("done_hold", 64'(lsu_state), 64'd3);
    @(negedge clk);
    cu_state = 4'h0;
    chk("idle_after_update", 64'(lsu_state), 64'd0);
  endtask

  task automatic run_op(input bit ld, input logic [NL-1:0] m,
                        input logic [NL*16-1:0] a, input logic [NL*16-1:0] d, input int lat);
    start_op(ld, m, a, d);
    finish_op(lat);
  endtask

  initial begin
    logic [NL*DW-1:0] snap;
    logic [NL-1:0]    m;
    bit               ld;
    int               c;
    reset = 1'b1;
    idle_inputs();
    do_reset();
    #2;
    chk("reset_state", 64'(lsu_state), 64'd0);
    chk("reset_data_out", lsu_data_out, 64'd0);
    chk("reset_req_vals", 64'({read_req_addr_val, write_req_val, read_resp_rdy, lsu_err}), 64'd0);

    // Zero-wait load across all four lanes.
    run_op(1'b1, 4'b1111, 64'h0013_0012_0011_0010, 64'h0, 9);
    chk("load_results", lsu_data_out, 64'hA013_A012_A011_A010);

    // Sparse store leaves the result registers alone.
    snap = model_vec();
    run_op(1'b0, 4'b0101, 64'h0004_0003_0002_0001, 64'h4444_3333_2222_1111, 5);
    chk("store_keeps_data", lsu_data_out, snap);

    // Stalled ready, delayed response and a stray write response.
    req_wait = 3; resp_delay = 2; spurious = 1'b1;
    run_op(1'b1, 4'b1111, {$urandom, $urandom}, 64'h0, -1);
    req_wait = 0; resp_delay = 0; spurious = 1'b0;

    // Empty mask completes immediately without traffic.
    run_op(1'b1, 4'b0000, {$urandom, $urandom}, 64'h0, 1);

    // Conflicting op select raises a one-cycle error and stays idle.
    @(negedge clk);
    lsu_en = 1'b1; cu_state = CU_REQ; mem_ren = 1'b1; mem_wen = 1'b1; lane_mask = 4'hF;
    @(negedge clk);
    idle_inputs();
    chk("err_pulse", 64'(lsu_err), 64'd1);
    chk("err_state", 64'(lsu_state), 64'd0);
    @(negedge clk);
    chk("err_clear", 64'(lsu_err), 64'd0);
    lsu_en = 1'b1; cu_state = CU_REQ; lane_mask = 4'hF;
    @(negedge clk);
    idle_inputs();
    chk("noop_err", 64'(lsu_err), 64'd0);
    chk("noop_state", 64'(lsu_state), 64'd0);

    // Retention across a narrower follow-up load.
    run_op(1'b1, 4'b1111, {$urandom, $urandom}, 64'h0, 9);
    snap = model_vec();
    run_op(1'b1, 4'b0010, {$urandom, $urandom}, 64'h0, 3);
    chk("retain_lane0", 64'(lsu_data_out[0 +: DW]), 64'(snap[0 +: DW]));
    chk("retain_lane2", 64'(lsu_data_out[2*DW +: DW]), 64'(snap[2*DW +: DW]));
    chk("retain_lane3", 64'(lsu_data_out[3*DW +: DW]), 64'(snap[3*DW +: DW]));

    // Randomised operations with random memory timing.
    for (int k = 0; k < 24; k++) begin
      ld         = 1'($urandom);
      m          = NL'($urandom);
      req_wait   = $urandom_range(0, 2);
      resp_delay = $urandom_range(0, 2);
      spurious   = 1'($urandom);
      run_op(ld, m, {$urandom, $urandom}, {$urandom, $urandom},
             (req_wait == 0 && resp_delay == 0) ? 1 + 2 * $countones(m) : -1);
    end
    req_wait = 0; resp_delay = 0; spurious = 1'b0;

    // Reset while waiting, with a response landing on the reset edge.
    resp_delay = 5;
    start_op(1'b1, 4'b0011, {$urandom, $urandom}, 64'h0);
    c = 0;
    while (lsu_state != 2'd2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (lsu_state != 2'd2) fail("wait_timeout", "never reached WAITING");
    reset = 1'b1; inject_resp = 1'b1;
    @(negedge clk);
    reset = 1'b0; inject_resp = 1'b0;
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    for (int i = 0; i < NL; i++) model_out[i] = '0;
    resp_delay = 0;
    chk("midreset_state", 64'(lsu_state), 64'd0);
    chk("midreset_data_out", lsu_data_out, 64'd0);
    chk("midreset_ctrl", 64'({read_req_addr_val, write_req_val, read_resp_rdy, lsu_err}), 64'd0);
    chk("midreset_buses", 64'({read_req_addr, write_req_addr, write_req_data}), 64'd0);
    @(negedge clk);
    chk("late_resp_dropped", lsu_data_out, 64'd0);
    run_op(1'b1, 4'b1000, 64'h0077_0000_0000_0000, 64'h0, 3);

    repeat (3) @(negedge clk);
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_multilane.md
# lsu_multilane

Parametrised successor to the single-lane load/store unit: one instance serves `NUM_LANES` thread lanes of a compute core. Lanes share a single memory read port and a single memory write port. On a compute-unit request phase it captures per-lane addresses and data under an active-lane mask, then issues one memory transaction per active lane in ascending lane order. It gathers load results into per-lane output registers and reports completion through `lsu_state`.

## Interface
Parameters:
- `DATA_ADDR_WIDTH`, 8: memory address width.
- `DATA_WIDTH`, 16: data/register width.
- `NUM_LANES`, 4: lane count, 1..16.
- `CU_REQUEST`, 4'b0011: `cu_state` value that triggers capture.
- `CU_UPDATE`, 4'b0110: `cu_state` value that releases DONE.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cu_state`  in  4  compute-unit phase.
- `lsu_en`  in  1  instruction is a memory op.
- `lane_mask`  in  NUM_LANES  active lanes, bit i = lane i.
- `mem_ren` / `mem_wen`  in  1 each  load / store select.
- `rs1`  in  NUM_LANES*16  per-lane address source, lane i at [16i+15:16i].
- `rs2`  in  NUM_LANES*16  per-lane store data.
- `lsu_data_out`  out  NUM_LANES*DATA_WIDTH  per-lane load results.
- `lsu_state`  out  2  0 IDLE, 1 REQUESTING, 2 WAITING, 3 DONE.
- `lsu_err`  out  1  one-cycle pulse on an illegal request.
- Read request: `read_req_rdy`  in  1; `read_req_addr`  out  DATA_ADDR_WIDTH; `read_req_addr_val`  out  1.
- Read response: `read_resp_rdy`  out  1; `read_resp_data`  in  DATA_WIDTH; `read_resp_data_val`  in  1.
- Write request: `write_req_rdy`  in  1; `write_req_addr`  out  DATA_ADDR_WIDTH; `write_req_data`  out  DATA_WIDTH; `write_req_val`  out  1.
- Write response: `write_resp_val`  in  1, single-cycle done pulse.

## Operation
- **IDLE, capture.** Acts only when `lsu_en && cu_state==CU_REQUEST`.
  - Captures the `rs1`/`rs2` lanes, `lane_mask` and the op into internal registers.
  - The lane address is `rs1` lane `[DATA_ADDR_WIDTH-1:0]` (truncated).
- **IDLE, decisions:**
  - Exactly one of `mem_ren`/`mem_wen` set and mask nonzero: pointer = lowest set lane; go to REQUESTING.
  - Mask zero: go straight to DONE; no memory traffic.
  - `mem_ren && mem_wen`: pulse `lsu_err`, stay IDLE, capture nothing.
  - Neither set: stay IDLE, no error.
- **REQUESTING.** Drives the request for the pointer lane.
  - Load: `read_req_addr_val=1`. Store: `write_req_val=1`, with `write_req_data` = captured `rs2` lane.
  - On `val && rdy`: go to WAITING.
- **WAITING:**
  - Load: `read_resp_rdy=1`. On `read_resp_data_val`: write `read_resp_data` into that lane's slot of `lsu_data_out`, then advance.
  - Store: advance on `write_resp_val`.
  - Advance: if a set mask bit exists above the pointer, move the pointer there and go to REQUESTING; otherwise go to DONE.
- **DONE.** Holds until `cu_state==CU_UPDATE`, then goes to IDLE.
- **Input capture.** `rs1`/`rs2`/`lane_mask` are ignored after capture; changes during the operation have no effect.
- **Data retention.** Masked-off lanes and all lanes of a store keep their previous `lsu_data_out` value.
- **Reset** (including mid-transaction): state IDLE; `lsu_data_out`, pointer and captured regs = 0.
  - All outputs are 0 after the reset edge.
  - An in-flight memory response arriving after reset is ignored.

## Timing
- Request/ready/state outputs are Moore: decoded from registered state only, with no combinational path from any `*_rdy`/`*_val` input.
- Addresses and data come from captured registers and are stable while `val` is high.
- `val` is held until accepted, and address/data do not change while held.
- A response that arrives while not in WAITING, or for the other op type, is ignored.
- Latency with a zero-wait memory (rdy=1 and response in the first WAITING cycle):
  - Capture edge, then 2 cycles per active lane.
  - DONE is visible 1+2K cycles after the capture cycle, for K active lanes.
- Mask zero: DONE is visible the cycle after capture.
- A result lane updates on the edge where its response is accepted; it is readable the next cycle.
- `cu_state==CU_REQUEST` outside IDLE is ignored; no re-capture.

## Structure
- Package `lsu_pkg`:
  - State localparams `LSU_IDLE`/`LSU_REQUESTING`/`LSU_WAITING`/`LSU_DONE`.
  - Default `CU_REQUEST`/`CU_UPDATE` encodings.
- Sub-module `lsu_next_lane`: combinational, parametrised by `NUM_LANES`.
  - Given mask and pointer, outputs the lowest set lane strictly above the pointer, plus a `found` flag.
  - A `first` mode returns the lowest set lane overall, used at capture.
- Top module holds the FSM, capture registers and result registers.

## Test plan
- Load, `NUM_LANES=4`, mask 4'b1111, lane i `rs1`=0x10+i, zero-wait memory returning 0xA000+addr:
  - Read addrs 0x10..0x13 issued in order.
  - `lsu_data_out` lanes = 0xA010..0xA013.
  - DONE at cycle 9; IDLE the cycle after `CU_UPDATE`.
- Store, mask 4'b0101, `rs2` lanes 0x1111/0x2222/0x3333/0x4444:
  - Exactly two writes: lane0 (0x1111), then lane2 (0x3333).
  - `lsu_data_out` unchanged.
- Load with `read_req_rdy` low 3 cycles, then response delayed 2 cycles:
  - `val` and addr held steady throughout.
  - Single transaction per lane; a spurious `write_resp_val` is ignored.
- Mask 0: DONE the cycle after capture, no request. Both `ren` and `wen` set: `lsu_err`=1 for one cycle, state stays 0.
- Reset asserted in WAITING with a response arriving the same cycle:
  - Next cycle: state 0, all outputs 0.
  - The late response is not written.
- Masked-lane retention: run a load with mask 1111, then a load with mask 0010. Lanes 0, 2 and 3 retain their first-run values.
